// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus operation encoding and the target-side FSM states.
package i2c_pkg;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef enum logic {
        I2C_OP_WRITE = I2C_RW_WRITE,
        I2C_OP_READ  = I2C_RW_READ
    } i2c_op_t;

    typedef enum logic [3:0] {
        TGT_IDLE     = 4'd0,
        TGT_ADDR     = 4'd1,
        TGT_ADDR_ACK = 4'd2,
        TGT_WR_DATA  = 4'd3,
        TGT_WR_ACK   = 4'd4,
        TGT_RD_LOAD  = 4'd5,
        TGT_RD_DATA  = 4'd6,
        TGT_RD_ACK   = 4'd7,
        TGT_IGNORE   = 4'd8
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser, run-length glitch filter and registered edge detect for one bus line.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic             sync1_r, sync2_r, level_r, rise_r, fall_r;
    logic [CNT_W-1:0] cnt_r;
    logic             differ_s, accept_s;

    // A new level is taken once FILT_LEN consecutive synchronised samples disagree with the current one.
    assign differ_s = (sync2_r != level_r);
    assign accept_s = differ_s && (cnt_r == CNT_W'(FILT_LEN - 1));

    // Synchroniser, filter counter and edge flags; idle bus level is high.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= line_i;
            sync2_r <= sync1_r;
            rise_r  <= accept_s & sync2_r;
            fall_r  <= accept_s & ~sync2_r;
            if (accept_s) begin
                level_r <= sync2_r;
                cnt_r   <= {CNT_W{1'b0}};
            end else if (differ_s) begin
                cnt_r   <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r   <= {CNT_W{1'b0}};
            end
        end
    end

    assign level_o = level_r;
    assign rise_o  = rise_r;
    assign fall_o  = fall_r;

endmodule

// File: rtl/i2c_target_fifo.sv
// I2C target: decodes bus conditions, ACKs its address, captures written bytes in a FIFO
// and serves read bytes from a valid/ready stream with optional SCL stretching.
module i2c_target_fifo
    import i2c_pkg::*;
#(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int WR_FIFO_DEPTH  = 4,
    parameter int FILT_LEN       = 3,
    parameter bit STRETCH_EN     = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    input  logic [I2C_ADDR_WIDTH-1:0] tgt_addr_i,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic                      wr_valid_o,
    input  logic                      wr_ready_i,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
    input  logic                      rd_valid_i,
    output logic                      rd_ready_o,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      overflow_o,
    output logic                      busy_o
);
    localparam int DW    = I2C_DATA_WIDTH;
    localparam int PTR_W = $clog2(WR_FIFO_DEPTH);
    localparam int CNT_W = $clog2(DW) + 1;

    if (I2C_ADDR_WIDTH != 7) begin : g_addr_width_check
        $error("i2c_target_fifo: I2C_ADDR_WIDTH must be 7");
    end
    if ((WR_FIFO_DEPTH < 2) || ((WR_FIFO_DEPTH & (WR_FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("i2c_target_fifo: WR_FIFO_DEPTH must be a power of two >= 2");
    end

    logic scl_lvl_s, scl_rise_s, scl_fall_s, sda_lvl_s, sda_rise_s, sda_fall_s;
    logic scl_held_s, start_det_s, stop_det_s;

    i2c_tgt_state_t   state_r, state_s;
    logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic [DW-1:0]    shift_r, shift_s, shift_in_s;
    logic             rw_r, rw_s, ack_r, ack_s, phase_r, phase_s;
    logic             sda_drv_r, sda_drv_s, scl_drv_r, scl_drv_s;
    logic             rd_ready_r, rd_ready_s, start_r, start_s, stop_r, stop_s;
    logic             ovf_r, ovf_s, busy_r, busy_s;

    logic [DW-1:0]    mem_r [WR_FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_r, rd_ptr_r;
    logic             fifo_full_s, fifo_empty_s, push_s, pop_s;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_i(clk_i), .rst_i(rst_i), .line_i(scl_i),
        .level_o(scl_lvl_s), .rise_o(scl_rise_s), .fall_o(scl_fall_s)
    );
    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_i(clk_i), .rst_i(rst_i), .line_i(sda_i),
        .level_o(sda_lvl_s), .rise_o(sda_rise_s), .fall_o(sda_fall_s)
    );

    // SCL must already have been high, so an SDA edge coinciding with an SCL rise
    // (stretch release presenting the MSB) is not mistaken for a bus condition.
    assign scl_held_s  = scl_lvl_s & ~scl_rise_s;
    assign start_det_s = sda_fall_s & scl_held_s;
    assign stop_det_s  = sda_rise_s & scl_held_s;

    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                          (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign pop_s        = wr_ready_i & ~fifo_empty_s;
    assign shift_in_s   = {shift_r[DW-2:0], sda_lvl_s};

    // Next-state and next-output logic of the target FSM.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        rw_s       = rw_r;
        ack_s      = ack_r;
        phase_s    = phase_r;
        sda_drv_s  = sda_drv_r;
        scl_drv_s  = scl_drv_r;
        busy_s     = busy_r;
        rd_ready_s = 1'b0;
        start_s    = 1'b0;
        stop_s     = 1'b0;
        ovf_s      = 1'b0;
        push_s     = 1'b0;
        if (start_det_s) begin
            state_s   = TGT_ADDR;
            bit_cnt_s = {CNT_W{1'b0}};
            sda_drv_s = 1'b0;
            scl_drv_s = 1'b0;
            start_s   = 1'b1;
            busy_s    = 1'b1;
        end else if (stop_det_s) begin
            state_s   = TGT_IDLE;
            sda_drv_s = 1'b0;
            scl_drv_s = 1'b0;
            stop_s    = 1'b1;
            busy_s    = 1'b0;
        end else begin
            case (state_r)
                TGT_ADDR: begin
                    if (scl_rise_s) begin
                        shift_s   = shift_in_s;
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                        phase_s   = 1'b0;
                        if (bit_cnt_r == CNT_W'(I2C_ADDR_WIDTH)) begin
                            rw_s    = shift_in_s[0];
                            state_s = (shift_in_s[I2C_ADDR_WIDTH:1] == tgt_addr_i) ? TGT_ADDR_ACK : TGT_IGNORE;
                        end else begin
                            state_s = TGT_ADDR;
                        end
                    end else begin
                        state_s = TGT_ADDR;
                    end
                end
                TGT_ADDR_ACK, TGT_WR_ACK: begin
                    // First SCL fall drives the ACK level, the second one releases it.
                    if (scl_fall_s && !phase_r) begin
                        sda_drv_s = (state_r == TGT_ADDR_ACK) ? 1'b1 : ack_r;
                        phase_s   = 1'b1;
                    end else if (scl_fall_s) begin
                        sda_drv_s = 1'b0;
                        bit_cnt_s = {CNT_W{1'b0}};
                        if (state_r == TGT_ADDR_ACK && rw_r == I2C_RW_READ) begin
                            state_s = TGT_RD_LOAD;
                        end else begin
                            state_s = TGT_WR_DATA;
                        end
                    end else begin
                        phase_s = phase_r;
                    end
                end
                TGT_WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_s   = shift_in_s;
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                        if (bit_cnt_r == CNT_W'(DW - 1)) begin
                            state_s = TGT_WR_ACK;
                            phase_s = 1'b0;
                            ack_s   = ~fifo_full_s;
                            push_s  = ~fifo_full_s;
                            ovf_s   = fifo_full_s;
                        end else begin
                            state_s = TGT_WR_DATA;
                        end
                    end else begin
                        state_s = TGT_WR_DATA;
                    end
                end
                TGT_RD_LOAD: begin
                    if (rd_valid_i) begin
                        shift_s    = rd_data_i;
                        rd_ready_s = 1'b1;
                        sda_drv_s  = ~rd_data_i[DW-1];
                        scl_drv_s  = 1'b0;
                        bit_cnt_s  = {CNT_W{1'b0}};
                        state_s    = TGT_RD_DATA;
                    end else if (STRETCH_EN) begin
                        scl_drv_s  = 1'b1;
                    end else begin
                        shift_s    = {DW{1'b1}};
                        sda_drv_s  = 1'b0;
                        bit_cnt_s  = {CNT_W{1'b0}};
                        state_s    = TGT_RD_DATA;
                    end
                end
                TGT_RD_DATA: begin
                    if (scl_fall_s && bit_cnt_r == CNT_W'(DW - 1)) begin
                        sda_drv_s = 1'b0;
                        state_s   = TGT_RD_ACK;
                    end else if (scl_fall_s) begin
                        sda_drv_s = ~shift_r[DW-2];
                        shift_s   = shift_r << 1;
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    end else begin
                        state_s   = TGT_RD_DATA;
                    end
                end
                TGT_RD_ACK: begin
                    if (scl_rise_s && sda_lvl_s) begin
                        state_s = TGT_IGNORE;
                    end else if (scl_fall_s) begin
                        state_s = TGT_RD_LOAD;
                    end else begin
                        state_s = TGT_RD_ACK;
                    end
                end
                TGT_IDLE, TGT_IGNORE: begin
                    state_s = state_r;
                end
                default: begin
                    state_s   = TGT_IDLE;
                    sda_drv_s = 1'b0;
                    scl_drv_s = 1'b0;
                end
            endcase
        end
    end

    // FSM state and registered bus/handshake outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r    <= TGT_IDLE;
            bit_cnt_r  <= {CNT_W{1'b0}};
            shift_r    <= {DW{1'b0}};
            rw_r       <= 1'b0;
            ack_r      <= 1'b0;
            phase_r    <= 1'b0;
            sda_drv_r  <= 1'b0;
            scl_drv_r  <= 1'b0;
            rd_ready_r <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            rw_r       <= rw_s;
            ack_r      <= ack_s;
            phase_r    <= phase_s;
            sda_drv_r  <= sda_drv_s;
            scl_drv_r  <= scl_drv_s;
            rd_ready_r <= rd_ready_s;
            start_r    <= start_s;
            stop_r     <= stop_s;
            ovf_r      <= ovf_s;
            busy_r     <= busy_s;
        end
    end

    // Write-capture FIFO; the extra pointer MSB separates full from empty.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < WR_FIFO_DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            wr_ptr_r <= {(PTR_W + 1){1'b0}};
            rd_ptr_r <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= shift_s;
                wr_ptr_r                   <= wr_ptr_r + (PTR_W + 1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W + 1)'(1);
            end
        end
    end

    assign scl_o      = scl_drv_r;
    assign sda_o      = sda_drv_r;
    assign wr_data_o  = mem_r[rd_ptr_r[PTR_W-1:0]];
    assign wr_valid_o = ~fifo_empty_s;
    assign rd_ready_o = rd_ready_r;
    assign start_o    = start_r;
    assign stop_o     = stop_r;
    assign overflow_o = ovf_r;
    assign busy_o     = busy_r;

endmodule

// File: tb/tb_i2c_target_fifo.sv
// Bench for i2c_target_fifo: bus-master model on a wired-AND bus with scoreboard queues.
module tb_i2c_target_fifo;

    localparam int H = 20;

    logic       clk = 1'b0;
    logic       rst_i, scl_m, sda_m, scl_bus, sda_bus, scl_o, sda_o;
    logic [6:0] tgt_addr;
    logic [7:0] wr_data_o, rd_data_i;
    logic       wr_valid_o, wr_ready_i, rd_valid_i, rd_ready_o;
    logic       start_o, stop_o, overflow_o, busy_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    int n_start = 0, n_stop = 0, n_ovf = 0, n_rdy = 0, n_sdao = 0, n_sclo = 0;
    logic [7:0] wr_q[$], rd_q[$], src_q[$];
    bit src_en = 1'b0;

    assign scl_bus = scl_m & ~scl_o;
    assign sda_bus = sda_m & ~sda_o;

    always #5 clk = ~clk;

    i2c_target_fifo #(
        .I2C_ADDR_WIDTH(7), .I2C_DATA_WIDTH(8), .WR_FIFO_DEPTH(4), .FILT_LEN(3), .STRETCH_EN(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_o(scl_o), .sda_o(sda_o), .tgt_addr_i(tgt_addr),
        .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
        .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o),
        .start_o(start_o), .stop_o(stop_o), .overflow_o(overflow_o), .busy_o(busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse and drive-activity counters sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (start_o)    n_start++;
            if (stop_o)     n_stop++;
            if (overflow_o) n_ovf++;
            if (rd_ready_o) n_rdy++;
            if (sda_o)      n_sdao++;
            if (scl_o)      n_sclo++;
        end
    end

    // Read-stream source: head of src_q is offered while src_en is set.
    initial begin
        rd_valid_i = 1'b0;
        rd_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_ready_o && src_q.size() > 0) void'(src_q.pop_front());
            rd_valid_i = src_en && (src_q.size() > 0);
            rd_data_i  = (src_q.size() > 0) ? src_q[0] : 8'hFF;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_high();
        scl_m = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (scl_bus) break;
        end
        if (!scl_bus) check_eq("scl_release_timeout", scl_bus, 1'b1);
    endtask

    task automatic m_bit_write(input logic b);
        sda_m = b;
        wait_cyc(H);
        scl_high();
        wait_cyc(H);
        scl_m = 1'b0;
        wait_cyc(4);
    endtask

    task automatic m_bit_read(output logic b);
        sda_m = 1'b1;
        wait_cyc(H);
        scl_high();
        wait_cyc(H / 2);
        b = sda_bus;
        wait_cyc(H / 2);
        scl_m = 1'b0;
        wait_cyc(4);
    endtask

    task automatic m_start();
        sda_m = 1'b1;
        wait_cyc(H);
        scl_high();
        wait_cyc(H);
        sda_m = 1'b0;
        wait_cyc(H);
        scl_m = 1'b0;
        wait_cyc(H);
    endtask

    task automatic m_stop();
        sda_m = 1'b0;
        wait_cyc(H);
        scl_high();
        wait_cyc(H);
        sda_m = 1'b1;
        wait_cyc(H);
    endtask

    task automatic m_write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) m_bit_write(b[i]);
        m_bit_read(ack);
    endtask

    task automatic m_read_expect(input string tag, input logic nack);
        logic [7:0] b;
        logic       v;
        for (int i = 7; i >= 0; i--) begin
            m_bit_read(v);
            b[i] = v;
        end
        m_bit_write(nack);
        if (rd_q.size() == 0) check_eq({tag, "_noexp"}, rd_q.size(), 1);
        else                  check_eq(tag, b, rd_q.pop_front());
    endtask

    task automatic drain_fifo(input string tag);
        logic [7:0] e;
        while (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            check_eq({tag, "_valid"}, wr_valid_o, 1'b1);
            check_eq({tag, "_data"}, wr_data_o, e);
            wr_ready_i = 1'b1;
            @(negedge clk);
            wr_ready_i = 1'b0;
        end
        check_eq({tag, "_empty"}, wr_valid_o, 1'b0);
    endtask

    task automatic check_idle_outs(input string tag);
        check_eq({tag, "_ctl"}, {scl_o, sda_o, wr_valid_o, rd_ready_o, start_o, stop_o, overflow_o, busy_o}, 8'h00);
        check_eq({tag, "_wdata"}, wr_data_o, 8'h00);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        int   b_start, b_stop, b_ovf, b_rdy, b_sdao, b_sclo;
        rst_i = 1'b0; scl_m = 1'b1; sda_m = 1'b1; wr_ready_i = 1'b0; tgt_addr = 7'h22;
        wait_cyc(3);
        check_idle_outs("reset");
        rst_i = 1'b1;
        wait_cyc(10);

        // Plain write of two bytes.
        b_start = n_start; b_stop = n_stop;
        m_start();
        check_eq("t1_busy", busy_o, 1'b1);
        m_write_byte(8'h44, ack); check_eq("t1_addr_ack", ack, 1'b0);
        wr_q.push_back(8'hA5); m_write_byte(8'hA5, ack); check_eq("t1_d0_ack", ack, 1'b0);
        wr_q.push_back(8'h3C); m_write_byte(8'h3C, ack); check_eq("t1_d1_ack", ack, 1'b0);
        m_stop();
        wait_cyc(10);
        check_eq("t1_starts", n_start - b_start, 1);
        check_eq("t1_stops", n_stop - b_stop, 1);
        check_eq("t1_busy_end", busy_o, 1'b0);
        drain_fifo("t1_fifo");

        // Address mismatch: target must stay silent.
        b_sdao = n_sdao;
        m_start();
        m_write_byte(8'h46, ack); check_eq("t2_addr_nack", ack, 1'b1);
        m_write_byte(8'h55, ack); check_eq("t2_data_nack", ack, 1'b1);
        m_stop();
        wait_cyc(10);
        check_eq("t2_sda_quiet", n_sdao - b_sdao, 0);
        check_eq("t2_fifo_empty", wr_valid_o, 1'b0);

        // FIFO overflow on the fifth byte.
        b_ovf = n_ovf;
        m_start();
        m_write_byte(8'h44, ack); check_eq("t3_addr_ack", ack, 1'b0);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] d;
            d = 8'h10 + 8'(i * 17);
            m_write_byte(d, ack);
            if (i < 4) begin
                wr_q.push_back(d);
                check_eq("t3_data_ack", ack, 1'b0);
            end else begin
                check_eq("t3_ovf_nack", ack, 1'b1);
            end
        end
        m_stop();
        wait_cyc(10);
        check_eq("t3_ovf_pulses", n_ovf - b_ovf, 1);
        drain_fifo("t3_fifo");

        // Read with clock stretching while no data is offered.
        b_rdy = n_rdy; b_sclo = n_sclo;
        src_en = 1'b0;
        src_q.push_back(8'h96); rd_q.push_back(8'h96);
        m_start();
        m_write_byte(8'h45, ack); check_eq("t4_addr_ack", ack, 1'b0);
        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    @(negedge clk);
                    if (scl_o) break;
                end
                if (!scl_o) check_eq("t4_stretch_start", scl_o, 1'b1);
                wait_cyc(200);
                src_en = 1'b1;
            end
            begin
                m_read_expect("t4_rdata", 1'b1);
            end
        join
        m_stop();
        wait_cyc(10);
        check_eq("t4_stretch_len", ((n_sclo - b_sclo) >= 195) && ((n_sclo - b_sclo) <= 205), 1'b1);
        check_eq("t4_rd_ready", n_rdy - b_rdy, 1);

        // Two-byte read, master NACK, repeated START into a write.
        b_rdy = n_rdy; b_start = n_start;
        src_q.push_back(8'h11); rd_q.push_back(8'h11);
        src_q.push_back(8'h22); rd_q.push_back(8'h22);
        m_start();
        m_write_byte(8'h45, ack); check_eq("t5_addr_ack", ack, 1'b0);
        m_read_expect("t5_rd0", 1'b0);
        m_read_expect("t5_rd1", 1'b1);
        m_start();
        m_write_byte(8'h44, ack); check_eq("t5_waddr_ack", ack, 1'b0);
        wr_q.push_back(8'h7E); m_write_byte(8'h7E, ack); check_eq("t5_wdata_ack", ack, 1'b0);
        m_stop();
        wait_cyc(10);
        check_eq("t5_rd_ready", n_rdy - b_rdy, 2);
        check_eq("t5_starts", n_start - b_start, 2);
        drain_fifo("t5_fifo");

        // Reset in the middle of a data byte, then a normal transfer.
        m_start();
        m_write_byte(8'h44, ack); check_eq("t6_addr_ack", ack, 1'b0);
        m_write_byte(8'h33, ack); check_eq("t6_d0_ack", ack, 1'b0);
        check_eq("t6_pre_valid", wr_valid_o, 1'b1);
        m_bit_write(1'b1); m_bit_write(1'b0); m_bit_write(1'b1); m_bit_write(1'b1);
        rst_i = 1'b0;
        @(negedge clk);
        check_idle_outs("t6_reset");
        rst_i = 1'b1;
        wait_cyc(10);
        m_stop();
        wait_cyc(10);
        b_start = n_start; b_stop = n_stop;
        m_start();
        m_write_byte(8'h44, ack); check_eq("t6_post_addr_ack", ack, 1'b0);
        wr_q.push_back(8'h5A); m_write_byte(8'h5A, ack); check_eq("t6_post_ack", ack, 1'b0);
        m_stop();
        wait_cyc(10);
        check_eq("t6_starts", n_start - b_start, 1);
        check_eq("t6_stops", n_stop - b_stop, 1);
        drain_fifo("t6_fifo");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
